// File: rtl/axis_packet_collector_pkg.sv
// Shared dispatcher/collector package.
// Holds the collector FSM encoding, the dispatcher FSM encoding that lives
// alongside it, packet-counter sizing and a saturating-increment helper.
package axis_packet_collector_pkg;

  // Collector FSM
  localparam int STATE_WIDTH = 1;
  localparam logic [STATE_WIDTH-1:0] COLL_IDLE    = 1'b0;
  localparam logic [STATE_WIDTH-1:0] COLL_FORWARD = 1'b1;

  // Dispatcher FSM (companion block sharing this package)
  localparam int DISP_STATE_WIDTH = 2;
  localparam logic [DISP_STATE_WIDTH-1:0] DISP_IDLE  = 2'd0;
  localparam logic [DISP_STATE_WIDTH-1:0] DISP_ROUTE = 2'd1;
  localparam logic [DISP_STATE_WIDTH-1:0] DISP_DRAIN = 2'd2;

  // Packet counter
  localparam int PKT_CNT_WIDTH = 32;
  localparam logic [PKT_CNT_WIDTH-1:0] PKT_CNT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PKT_CNT_WIDTH-1:0] sat_inc(input logic [PKT_CNT_WIDTH-1:0] v);
    return (v == PKT_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_packet_collector_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search.
// Ports:
//   req         in  N      request vector
//   last_grant  in  IDX_W  most recently served index
//   grant       out IDX_W  first requester at or after last_grant+1 (mod N)
//   grant_valid out 1      any request present
module rr_priority_picker #(
  parameter int IDX_W = 2,
  parameter int N     = 2**IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  logic [IDX_W-1:0] idx;

  // N is a power of two, so IDX_W-bit wraparound is the modulo. The final
  // step (i == N) lands back on last_grant, giving it lowest priority.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 1; i <= N; i++) begin
      idx = last_grant + IDX_W'(i);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_collector.sv
// axis_packet_collector: merges N = 2**AXIS_DEST_WIDTH AXI-Stream inputs into
// one output, whole packets at a time, round-robin between packets.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_collector_*       N input streams, port i in slice i
//   m_axis_collector_*       merged output stream; tdest = source port
//   enable_collector         allows new grants (never cuts a packet short)
//   rst_pkt_counter          clears reg_pkt_counter (wins over an increment)
//   reg_pkt_counter          saturating count of forwarded packets
module axis_packet_collector
  import axis_packet_collector_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_DEST_WIDTH = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [(2**AXIS_DEST_WIDTH)*AXIS_DATA_WIDTH-1:0] s_axis_collector_tdata,
  input  logic [(2**AXIS_DEST_WIDTH)*AXIS_KEEP_WIDTH-1:0] s_axis_collector_tkeep,
  input  logic [(2**AXIS_DEST_WIDTH)-1:0]             s_axis_collector_tvalid,
  input  logic [(2**AXIS_DEST_WIDTH)-1:0]             s_axis_collector_tlast,
  output logic [(2**AXIS_DEST_WIDTH)-1:0]             s_axis_collector_tready,
  output logic [AXIS_DATA_WIDTH-1:0]                  m_axis_collector_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]                  m_axis_collector_tkeep,
  output logic                                        m_axis_collector_tvalid,
  output logic                                        m_axis_collector_tlast,
  output logic [AXIS_DEST_WIDTH-1:0]                  m_axis_collector_tdest,
  input  logic                                        m_axis_collector_tready,
  input  logic                                        enable_collector,
  input  logic                                        rst_pkt_counter,
  output logic [PKT_CNT_WIDTH-1:0]                    reg_pkt_counter
);

  localparam int N = 2**AXIS_DEST_WIDTH;

  logic [STATE_WIDTH-1:0]     state;
  logic [AXIS_DEST_WIDTH-1:0] grant, last_grant, pick;
  logic                       pick_valid;
  logic                       hs_last;

  // Per-port views of the flat input buses
  logic [N-1:0][AXIS_DATA_WIDTH-1:0] in_data;
  logic [N-1:0][AXIS_KEEP_WIDTH-1:0] in_keep;

  for (genvar p = 0; p < N; p++) begin : g_port
    assign in_data[p] = s_axis_collector_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign in_keep[p] = s_axis_collector_tkeep[p*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
  end

  rr_priority_picker #(.IDX_W(AXIS_DEST_WIDTH), .N(N)) u_picker (
    .req         (s_axis_collector_tvalid),
    .last_grant  (last_grant),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  // Combinational forward path; everything is held at zero while idle.
  always_comb begin
    m_axis_collector_tdata  = '0;
    m_axis_collector_tkeep  = '0;
    m_axis_collector_tvalid = 1'b0;
    m_axis_collector_tlast  = 1'b0;
    m_axis_collector_tdest  = '0;
    s_axis_collector_tready = '0;
    if (state == COLL_FORWARD) begin
      m_axis_collector_tdata         = in_data[grant];
      m_axis_collector_tkeep         = in_keep[grant];
      m_axis_collector_tvalid        = s_axis_collector_tvalid[grant];
      m_axis_collector_tlast         = s_axis_collector_tlast[grant];
      m_axis_collector_tdest         = grant;
      s_axis_collector_tready[grant] = m_axis_collector_tready;
    end
  end

  assign hs_last = (state == COLL_FORWARD) && m_axis_collector_tvalid &&
                   m_axis_collector_tready && m_axis_collector_tlast;

  // enable_collector only gates the IDLE->FORWARD decision, so a packet in
  // flight always runs to its tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLL_IDLE;
      grant      <= '0;
      last_grant <= AXIS_DEST_WIDTH'(N-1);
    end else begin
      case (state)
        COLL_IDLE: begin
          if (enable_collector && pick_valid) begin
            grant <= pick;
            state <= COLL_FORWARD;
          end
        end
        default: begin
          if (hs_last) begin
            last_grant <= grant;
            state      <= COLL_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rst_pkt_counter) reg_pkt_counter <= '0;
    else if (hs_last)           reg_pkt_counter <= sat_inc(reg_pkt_counter);
  end

endmodule

// File: tb/tb_axis_packet_collector.sv
// Directed bench for axis_packet_collector (4 ports, 64-bit data).
// Per-port upstream sources are driven from tasks; outputs are sampled on the
// falling edge and accepted output beats are logged for ordering checks.
module tb_axis_packet_collector;

  localparam int W = 64;
  localparam int K = 8;
  localparam int D = 2;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_tdata;
  logic [N*K-1:0] s_tkeep;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [W-1:0]   m_tdata;
  logic [K-1:0]   m_tkeep;
  logic           m_tvalid, m_tlast, m_tready;
  logic [D-1:0]   m_tdest;
  logic           enable, rst_cnt;
  logic [31:0]    cnt;

  int checks = 0;
  int failures = 0;

  axis_packet_collector #(.AXIS_DATA_WIDTH(W), .AXIS_KEEP_WIDTH(K), .AXIS_DEST_WIDTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_axis_collector_tdata(s_tdata), .s_axis_collector_tkeep(s_tkeep),
    .s_axis_collector_tvalid(s_tvalid), .s_axis_collector_tlast(s_tlast),
    .s_axis_collector_tready(s_tready),
    .m_axis_collector_tdata(m_tdata), .m_axis_collector_tkeep(m_tkeep),
    .m_axis_collector_tvalid(m_tvalid), .m_axis_collector_tlast(m_tlast),
    .m_axis_collector_tdest(m_tdest), .m_axis_collector_tready(m_tready),
    .enable_collector(enable), .rst_pkt_counter(rst_cnt), .reg_pkt_counter(cnt)
  );

  always #5 clk = ~clk;

  // Upstream source state
  int src_active[N];
  int src_len[N];
  int src_beat[N];
  int src_tag[N];

  // Samples from the last falling edge
  logic         smp_valid, smp_last;
  logic [W-1:0] smp_data;
  logic [K-1:0] smp_keep;
  logic [D-1:0] smp_dest;
  logic [N-1:0] smp_sready;

  // Accepted output beats
  logic [W-1:0] log_data[$];
  int           log_dest[$];
  logic         log_last[$];

  function automatic logic [W-1:0] mk_data(int p, int tag, int j);
    return {8'(p + 1), 8'(tag), 16'(j), 32'hC0DE_0000 + 32'(j)};
  endfunction

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      s_tvalid[p]       = (src_active[p] != 0);
      s_tlast[p]        = (src_active[p] != 0) && (src_beat[p] == src_len[p] - 1);
      s_tdata[p*W +: W] = (src_active[p] != 0) ? mk_data(p, src_tag[p], src_beat[p]) : '0;
      s_tkeep[p*K +: K] = (src_active[p] != 0) ? ((src_beat[p] == src_len[p] - 1) ? 8'h0F : 8'hFF) : '0;
    end
  endtask

  task automatic post(int p, int len, int tag);
    src_active[p] = 1; src_len[p] = len; src_beat[p] = 0; src_tag[p] = tag;
    drive();
  endtask

  task automatic clear_sources();
    for (int p = 0; p < N; p++) begin
      src_active[p] = 0; src_len[p] = 0; src_beat[p] = 0; src_tag[p] = 0;
    end
    drive();
  endtask

  task automatic clear_log();
    log_data.delete(); log_dest.delete(); log_last.delete();
  endtask

  // One clock: sample at the falling edge, then update sources just after
  // the rising edge according to the handshakes seen.
  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    smp_valid = m_tvalid; smp_last = m_tlast; smp_data = m_tdata;
    smp_keep = m_tkeep; smp_dest = m_tdest; smp_sready = s_tready;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      log_data.push_back(m_tdata); log_dest.push_back(int'(m_tdest)); log_last.push_back(m_tlast);
    end
    @(posedge clk); #1;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        src_beat[p]++;
        if (src_beat[p] == src_len[p]) src_active[p] = 0;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; m_tready = 1'b1; rst_cnt = 1'b0;
    clear_sources();
    cycle(); cycle();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; m_tready = 1'b1; rst_cnt = 1'b0;
    clear_sources();
    post(0, 2, 1);
    cycle(); cycle();
    checks++; if (smp_valid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%0b exp=0", smp_valid); end
    checks++; if (smp_sready !== 4'b0000) begin failures++; $display("FAIL reset_sready got=%b exp=0000", smp_sready); end
    checks++; if (smp_data !== 64'd0 || smp_dest !== 2'd0) begin failures++; $display("FAIL reset_payload got=%0h/%0d exp=0/0", smp_data, smp_dest); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    rst = 1'b0;
    clear_sources();
    clear_log();
  endtask

  task automatic test_single_packet();
    do_reset();
    post(2, 3, 3);
    cycle();
    checks++; if (smp_valid !== 1'b0 || log_data.size() != 0) begin failures++; $display("FAIL single_bubble got=%0b exp=0", smp_valid); end
    cycle();
    checks++; if (smp_valid !== 1'b1 || smp_dest !== 2'd2 || smp_sready !== 4'b0100) begin
      failures++; $display("FAIL single_first got=%0b/%0d/%b exp=1/2/0100", smp_valid, smp_dest, smp_sready); end
    repeat (4) cycle();
    checks++; if (log_data.size() != 3) begin failures++; $display("FAIL single_beats got=%0d exp=3", log_data.size()); end
    else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (log_data[j] !== mk_data(2, 3, j) || log_dest[j] != 2 || log_last[j] !== (j == 2)) begin
          failures++; $display("FAIL single_beat%0d got=%0h/%0d exp=%0h/2", j, log_data[j], log_dest[j], mk_data(2, 3, j)); end
      end
    end
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", cnt); end
  endtask

  task automatic test_all_ports();
    do_reset();
    for (int p = 0; p < N; p++) post(p, 2, 20 + p);
    repeat (14) cycle();
    checks++; if (log_data.size() != 8) begin failures++; $display("FAIL rr_beats got=%0d exp=8", log_data.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_dest[i] != i/2 || log_data[i] !== mk_data(i/2, 20 + i/2, i%2) || log_last[i] !== (i%2 == 1)) begin
          failures++; $display("FAIL rr_beat%0d got=%0d/%0h exp=%0d/%0h", i, log_dest[i], log_data[i], i/2, mk_data(i/2, 20 + i/2, i%2)); end
      end
    end
    checks++; if (cnt !== 32'd4) begin failures++; $display("FAIL rr_cnt got=%0d exp=4", cnt); end
  endtask

  task automatic test_backpressure();
    int pat[4] = '{1, 0, 0, 1};
    int expb[4] = '{0, 1, 1, 1};
    do_reset();
    post(1, 4, 5);
    cycle();
    post(3, 2, 6);
    for (int k = 0; k < 4; k++) begin
      m_tready = pat[k][0];
      cycle();
      checks++;
      if (smp_valid !== 1'b1 || smp_dest !== 2'd1 || smp_data !== mk_data(1, 5, expb[k]) ||
          smp_sready !== (pat[k] != 0 ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL bp_cyc%0d got=%0b/%0d/%0h/%b exp=1/1/%0h/%b", k, smp_valid, smp_dest, smp_data,
                             smp_sready, mk_data(1, 5, expb[k]), (pat[k] != 0 ? 4'b0010 : 4'b0000)); end
    end
    m_tready = 1'b1;
    repeat (8) cycle();
    checks++; if (log_data.size() != 6) begin failures++; $display("FAIL bp_beats got=%0d exp=6", log_data.size()); end
    else begin
      checks++; if (log_data[1] !== mk_data(1, 5, 1) || log_data[3] !== mk_data(1, 5, 3) || log_dest[3] != 1) begin
        failures++; $display("FAIL bp_order got=%0h/%0h exp=%0h/%0h", log_data[1], log_data[3], mk_data(1, 5, 1), mk_data(1, 5, 3)); end
      checks++; if (log_dest[4] != 3 || log_dest[5] != 3) begin failures++; $display("FAIL bp_next got=%0d exp=3", log_dest[4]); end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    post(3, 4, 7);
    cycle(); cycle();
    enable = 1'b0;
    post(0, 2, 8);
    repeat (8) cycle();
    checks++; if (log_data.size() != 4 || log_dest[3] != 3 || log_last[3] !== 1'b1) begin
      failures++; $display("FAIL en_complete got=%0d beats exp=4", log_data.size()); end
    checks++; if (smp_valid !== 1'b0 || smp_sready !== 4'b0000) begin
      failures++; $display("FAIL en_hold got=%0b/%b exp=0/0000", smp_valid, smp_sready); end
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL en_cnt1 got=%0d exp=1", cnt); end
    enable = 1'b1;
    repeat (5) cycle();
    checks++; if (log_data.size() != 6 || log_dest[4] != 0 || log_data[4] !== mk_data(0, 8, 0)) begin
      failures++; $display("FAIL en_resume got=%0d beats exp=6", log_data.size()); end
    checks++; if (cnt !== 32'd2) begin failures++; $display("FAIL en_cnt2 got=%0d exp=2", cnt); end
  endtask

  task automatic test_counter_clear();
    do_reset();
    post(0, 1, 9);
    repeat (3) cycle();
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL clr_pre got=%0d exp=1", cnt); end
    post(1, 1, 10);
    cycle();
    rst_cnt = 1'b1;
    cycle();
    rst_cnt = 1'b0;
    checks++; if (smp_valid !== 1'b1 || smp_last !== 1'b1 || smp_keep !== 8'h0F) begin
      failures++; $display("FAIL clr_single got=%0b/%0b/%0h exp=1/1/0f", smp_valid, smp_last, smp_keep); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL clr_win got=%0d exp=0", cnt); end
    cycle();
    checks++; if (smp_valid !== 1'b0) begin failures++; $display("FAIL clr_onebeat got=%0b exp=0", smp_valid); end
    post(2, 1, 11);
    repeat (3) cycle();
    checks++; if (cnt !== 32'd1) begin failures++; $display("FAIL clr_post got=%0d exp=1", cnt); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    post(2, 5, 12);
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    src_active[2] = 0;
    post(0, 2, 13);
    post(3, 2, 14);
    clear_log();
    cycle();
    checks++; if (smp_valid !== 1'b0 || smp_sready !== 4'b0000) begin
      failures++; $display("FAIL rstmid_idle got=%0b/%b exp=0/0000", smp_valid, smp_sready); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", cnt); end
    repeat (7) cycle();
    checks++; if (log_data.size() != 4 || log_dest[0] != 0 || log_dest[2] != 3) begin
      failures++; $display("FAIL rstmid_prio got=%0d beats first=%0d exp=4 first=0",
                           log_data.size(), (log_dest.size() > 0) ? log_dest[0] : -1); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; m_tready = 1'b1; rst_cnt = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
    test_reset();
    test_single_packet();
    test_all_ports();
    test_backpressure();
    test_enable_drop();
    test_counter_clear();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_packet_collector.md
AXIS_PACKET_COLLECTOR -- requirements
Module: axis_packet_collector

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, the per-beat data width.
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, the byte-enable width.
REQ-003 SHALL have parameter AXIS_DEST_WIDTH, default 2; the number of input ports is N = 2**AXIS_DEST_WIDTH.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- s_axis_collector_tdata  in  N*AXIS_DATA_WIDTH  port i data in slice i
- s_axis_collector_tkeep  in  N*AXIS_KEEP_WIDTH  port i keep in slice i
- s_axis_collector_tvalid  in  N  per-port valid
- s_axis_collector_tlast  in  N  per-port last
- s_axis_collector_tready  out  N  per-port ready
- m_axis_collector_tdata  out  AXIS_DATA_WIDTH  merged data
- m_axis_collector_tkeep  out  AXIS_KEEP_WIDTH  merged keep
- m_axis_collector_tvalid  out  1  merged valid
- m_axis_collector_tlast  out  1  merged last
- m_axis_collector_tdest  out  AXIS_DEST_WIDTH  index of the source port
- m_axis_collector_tready  in  1  downstream ready
- enable_collector  in  1  permits new grants
- rst_pkt_counter  in  1  clears the packet counter
- reg_pkt_counter  out  32  count of forwarded packets

Function
REQ-006 SHALL merge the N input streams into one output stream, packet-atomically; a granted packet SHALL NOT be interleaved with beats from any other port.
REQ-007 SHALL implement the two-state FSM IDLE and FORWARD.
REQ-008 IDLE: if enable_collector=1 and any tvalid is high, the FSM SHALL register grant = the first requesting port found by searching upward from last_grant+1 modulo N, and SHALL enter FORWARD on the next cycle.
REQ-009 Arbitration SHALL cost one idle cycle between packets.
REQ-010 In IDLE, all s_axis_collector_tready bits SHALL be 0; m_axis_collector_tvalid, tdata, tkeep, tlast and tdest SHALL be 0.
REQ-011 In FORWARD, the data path SHALL be combinational:
- m_tdata, m_tkeep, m_tlast and m_tvalid = the granted port's signals
- m_tdest = grant
- s_tready[grant] = m_axis_collector_tready
- all other tready bits = 0
REQ-012 In FORWARD, a handshake with tlast=1 (tvalid & tready & tlast) SHALL set last_grant to grant, return the FSM to IDLE, and increment the counter.
REQ-013 Deasserting enable_collector mid-packet SHALL NOT truncate the packet; the current packet completes and no new grant is issued while enable_collector=0.
REQ-014 m_axis_collector_tdest SHALL remain stable for the whole packet.
REQ-015 Output valid and payload SHALL hold while m_axis_collector_tready=0; back-pressure propagates only to the granted port.
REQ-016 reg_pkt_counter SHALL saturate at 0xFFFFFFFF.
REQ-017 If rst_pkt_counter and a tlast handshake occur in the same cycle, rst_pkt_counter SHALL win and the counter reads 0 next cycle.
REQ-018 A single-beat packet (tlast on the first beat) SHALL be forwarded in one FORWARD cycle when tready=1.

Reset
REQ-019 rst SHALL force state=IDLE, grant=0, last_grant=N-1 (so port 0 has first priority), and reg_pkt_counter=0.
REQ-020 Reset mid-packet SHALL abandon the grant at once; on the following cycle all tready outputs and m_axis_collector_tvalid SHALL be 0; recovery of upstream partial packets is the upstream's responsibility.

Structure
REQ-021 State encoding (IDLE=0, FORWARD=1) and the STATE_WIDTH constant SHALL live in the shared dispatcher package alongside the dispatcher state constants.
REQ-022 The round-robin search SHALL be a sub-module rr_priority_picker:
- inputs: request vector, last_grant
- outputs: grant index, grant_valid
- purely combinational

Verification
REQ-023 Single 3-beat packet on port 2, tready=1 → grant after a 1-cycle bubble; 3 output beats with tdest=2; counter=1.
REQ-024 All four ports post a 2-beat packet at once after reset → output order is ports 0,1,2,3; each packet is contiguous; counter=4.
REQ-025 Port 1 packet with m_tready toggled 1,0,0,1 → data held stable; only s_tready[1] follows m_tready; no other port is accepted.
REQ-026 enable_collector dropped after beat 1 of a 4-beat packet on port 3 → all 4 beats complete; a pending port 0 packet is not granted until enable returns to 1.
REQ-027 rst_pkt_counter asserted in the same cycle as a tlast handshake → counter=0; the next packet makes it 1.
REQ-028 rst asserted on beat 2 of a 5-beat packet → next cycle tvalid=0 and tready=0000; after reset, port 0 has priority.
